// File: rtl/btn_probe_pkg.sv
// Shared definitions for the button debounce / LED toggle probe source.
//   - db_state_e  : debounce FSM state encoding
//   - db_cycles() : stable-time length in clock cycles from clock rate and ms
//   - PRESS_CNT_W : width of the debounced press counter
package btn_probe_pkg;

  typedef enum logic [1:0] {
    REL    = 2'd0,
    WAIT_P = 2'd1,
    PRS    = 2'd2,
    WAIT_R = 2'd3
  } db_state_e;

  localparam int PRESS_CNT_W = 8;

  // Computed in 64 bits so large clock rates do not overflow; a zero result is
  // clamped to one cycle so the counter always has something to count.
  function automatic int db_cycles(input int clk_hz, input int debounce_ms);
    longint c;
    c = (longint'(clk_hz) * longint'(debounce_ms)) / 64'sd1000;
    if (c < 1) c = 1;
    return int'(c);
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Button synchroniser and debouncer.
//   i_clk    : system clock
//   i_rst_n  : synchronous reset, active-low
//   i_btn    : raw asynchronous button pin
//   o_btn    : debounced level, active-high (1 = pressed)
//
// state  | meaning
// REL    | released, waiting for a pressed sample
// WAIT_P | pressed samples seen, counting stable time
// PRS    | pressed, waiting for a released sample
// WAIT_R | released samples seen, counting stable time
module btn_debounce
  import btn_probe_pkg::*;
#(
  parameter int DB_CYCLES      = 4,
  parameter int SYNC_STAGES    = 2,
  parameter int BTN_ACTIVE_LOW = 1
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_btn,
  output logic o_btn
);

  localparam int               CNT_W        = $clog2(DB_CYCLES + 1);
  localparam logic             RAW_RELEASED = (BTN_ACTIVE_LOW != 0);
  localparam logic [CNT_W-1:0] CNT_MAX      = CNT_W'(DB_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   w_s;
  db_state_e              r_state;
  db_state_e              w_state_nxt;
  logic [CNT_W-1:0]       r_cnt;
  logic [CNT_W-1:0]       w_cnt_nxt;
  logic                   r_btn;
  logic                   w_btn_nxt;

  // Reset preloads the chain with the released pin level so leaving reset
  // never looks like an edge.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) r_sync <= {SYNC_STAGES{RAW_RELEASED}};
    else          r_sync <= {r_sync[SYNC_STAGES-2:0], i_btn};
  end

  // XOR with the released level normalises to active-high.
  assign w_s = r_sync[SYNC_STAGES-1] ^ RAW_RELEASED;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state <= REL;
      r_cnt   <= '0;
      r_btn   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_btn   <= w_btn_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_btn_nxt   = r_btn;
    unique case (r_state)
      REL: begin
        if (w_s) begin
          w_state_nxt = WAIT_P;
          w_cnt_nxt   = CNT_ONE;
        end
      end
      WAIT_P: begin
        if (!w_s) begin
          w_state_nxt = REL;
          w_cnt_nxt   = '0;
        end else if (r_cnt == CNT_MAX) begin
          w_state_nxt = PRS;
          w_cnt_nxt   = '0;
          w_btn_nxt   = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + CNT_ONE;
        end
      end
      PRS: begin
        if (!w_s) begin
          w_state_nxt = WAIT_R;
          w_cnt_nxt   = CNT_ONE;
        end
      end
      WAIT_R: begin
        if (w_s) begin
          w_state_nxt = PRS;
          w_cnt_nxt   = '0;
        end else if (r_cnt == CNT_MAX) begin
          w_state_nxt = REL;
          w_cnt_nxt   = '0;
          w_btn_nxt   = 1'b0;
        end else begin
          w_cnt_nxt = r_cnt + CNT_ONE;
        end
      end
      default: begin
        w_state_nxt = REL;
        w_cnt_nxt   = '0;
        w_btn_nxt   = 1'b0;
      end
    endcase
  end

  assign o_btn = r_btn;

endmodule

// File: rtl/btn_debounce_toggle.sv
// Probe source stage: debounced button, press strobe, LED toggle, press
// counter and held-off analyser trigger.
//   i_clk       : system clock
//   i_rst_n     : synchronous reset, active-low
//   i_btn       : raw asynchronous button pin
//   o_btn       : debounced level, active-high
//   o_btn_old   : o_btn delayed one cycle
//   o_led       : LED drive, toggles once per debounced press
//   o_trigger   : one-cycle analyser trigger pulse
//   o_press_cnt : debounced press count, wraps
module btn_debounce_toggle
  import btn_probe_pkg::*;
#(
  parameter int CLK_HZ         = 27_000_000,
  parameter int DEBOUNCE_MS    = 10,
  parameter int SYNC_STAGES    = 2,
  parameter int BTN_ACTIVE_LOW = 1,
  parameter int TRIG_HOLDOFF   = 16
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_btn,
  output logic                   o_btn,
  output logic                   o_btn_old,
  output logic                   o_led,
  output logic                   o_trigger,
  output logic [PRESS_CNT_W-1:0] o_press_cnt
);

  localparam int DB_CYCLES = db_cycles(CLK_HZ, DEBOUNCE_MS);
  // Keep at least one bit so TRIG_HOLDOFF=0 still elaborates.
  localparam int HOLD_W    = (TRIG_HOLDOFF < 1) ? 1 : $clog2(TRIG_HOLDOFF + 1);

  logic                   w_btn;
  logic                   w_press;
  logic                   w_trig;
  logic                   r_btn_old;
  logic                   r_led;
  logic                   r_trigger;
  logic [PRESS_CNT_W-1:0] r_press_cnt;
  logic [HOLD_W-1:0]      r_hold;

  btn_debounce #(
    .DB_CYCLES      (DB_CYCLES),
    .SYNC_STAGES    (SYNC_STAGES),
    .BTN_ACTIVE_LOW (BTN_ACTIVE_LOW)
  ) u_debounce (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_btn   (i_btn),
    .o_btn   (w_btn)
  );

  assign w_press = w_btn & ~r_btn_old;
  assign w_trig  = w_press & (r_hold == '0);

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_btn_old   <= 1'b0;
      r_led       <= 1'b0;
      r_trigger   <= 1'b0;
      r_press_cnt <= '0;
      r_hold      <= '0;
    end else begin
      r_btn_old <= w_btn;
      r_trigger <= w_trig;
      if (w_press) begin
        r_led       <= ~r_led;
        r_press_cnt <= r_press_cnt + PRESS_CNT_W'(1);
      end
      // Presses inside the hold-off window still toggle and count.
      if (w_trig)            r_hold <= HOLD_W'(TRIG_HOLDOFF);
      else if (r_hold != '0) r_hold <= r_hold - HOLD_W'(1);
    end
  end

  assign o_btn       = w_btn;
  assign o_btn_old   = r_btn_old;
  assign o_led       = r_led;
  assign o_trigger   = r_trigger;
  assign o_press_cnt = r_press_cnt;

endmodule

// File: tb/tb_btn_debounce_toggle.sv
module tb_btn_debounce_toggle;

  localparam int DB     = 4;
  localparam int SYNC   = 2;
  localparam int HOLD_A = 3;
  localparam int HOLD_B = 20;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic btn = 1'b0;

  logic a_btn, a_old, a_led, a_trig;
  logic [7:0] a_cnt;
  logic b_btn, b_old, b_led, b_trig;
  logic [7:0] b_cnt;

  int checks = 0;
  int errors = 0;
  int ntrig_a = 0;
  int ntrig_b = 0;

  // Behavioural reference: raw pin history, run length of samples that
  // disagree with the debounced level, and per-instance hold-off timers.
  logic raw_hist[$] = '{1'b1, 1'b1};
  logic m_lvl = 1'b0;
  logic m_old = 1'b0;
  logic m_led = 1'b0;
  logic [7:0] m_cnt = 8'd0;
  int m_run = 0;
  logic m_trig[2] = '{1'b0, 1'b0};
  int m_hold[2] = '{0, 0};

  typedef struct {
    logic btn;
    logic e_btn, e_old, e_led, e_trig;
    logic [7:0] e_cnt;
  } vec_t;
  vec_t vec[1:22];

  btn_debounce_toggle #(
    .CLK_HZ(1000), .DEBOUNCE_MS(4), .SYNC_STAGES(SYNC),
    .BTN_ACTIVE_LOW(1), .TRIG_HOLDOFF(HOLD_A)
  ) dut_a (
    .i_clk(clk), .i_rst_n(rst_n), .i_btn(btn),
    .o_btn(a_btn), .o_btn_old(a_old), .o_led(a_led),
    .o_trigger(a_trig), .o_press_cnt(a_cnt)
  );

  btn_debounce_toggle #(
    .CLK_HZ(1000), .DEBOUNCE_MS(4), .SYNC_STAGES(SYNC),
    .BTN_ACTIVE_LOW(1), .TRIG_HOLDOFF(HOLD_B)
  ) dut_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_btn(btn),
    .o_btn(b_btn), .o_btn_old(b_old), .o_led(b_led),
    .o_trigger(b_trig), .o_press_cnt(b_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    logic press, s;
    int hv;
    if (!rst_n) begin
      raw_hist = '{1'b1, 1'b1};
      m_lvl = 1'b0; m_old = 1'b0; m_led = 1'b0; m_cnt = 8'd0; m_run = 0;
      for (int k = 0; k < 2; k++) begin m_trig[k] = 1'b0; m_hold[k] = 0; end
    end else begin
      press = m_lvl & ~m_old;
      s = ~raw_hist[SYNC-1];
      raw_hist.push_front(btn);
      void'(raw_hist.pop_back());
      m_old = m_lvl;
      if (s != m_lvl) begin
        m_run++;
        if (m_run == DB + 1) begin m_lvl = s; m_run = 0; end
      end else begin
        m_run = 0;
      end
      if (press) begin m_led = ~m_led; m_cnt = m_cnt + 8'd1; end
      for (int k = 0; k < 2; k++) begin
        hv = (k == 0) ? HOLD_A : HOLD_B;
        m_trig[k] = press && (m_hold[k] == 0);
        if (m_trig[k]) m_hold[k] = hv;
        else if (m_hold[k] > 0) m_hold[k]--;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    if (a_trig) ntrig_a++;
    if (b_trig) ntrig_b++;
    chk("model_a_btn", {7'd0, a_btn}, {7'd0, m_lvl});
    chk("model_a_old", {7'd0, a_old}, {7'd0, m_old});
    chk("model_a_led", {7'd0, a_led}, {7'd0, m_led});
    chk("model_a_cnt", a_cnt, m_cnt);
    chk("model_a_trig", {7'd0, a_trig}, {7'd0, m_trig[0]});
    chk("model_b_btn", {7'd0, b_btn}, {7'd0, m_lvl});
    chk("model_b_led", {7'd0, b_led}, {7'd0, m_led});
    chk("model_b_cnt", b_cnt, m_cnt);
    chk("model_b_trig", {7'd0, b_trig}, {7'd0, m_trig[1]});
  endtask

  task automatic hold_btn(input logic v, input int n);
    btn = v;
    repeat (n) tick();
  endtask

  task automatic press_release();
    hold_btn(1'b0, 7);
    hold_btn(1'b1, 7);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    btn = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    btn = 1'b1;
  endtask

  initial begin
    for (int c = 1; c <= 22; c++) begin
      vec[c].btn    = (c < 10);
      vec[c].e_btn  = (c >= 16);
      vec[c].e_old  = (c >= 17);
      vec[c].e_led  = (c >= 17);
      vec[c].e_trig = (c == 17);
      vec[c].e_cnt  = (c >= 17) ? 8'd1 : 8'd0;
    end

    // 1: reset with pin low, then outputs all zero
    do_reset();
    chk("rst_btn", {7'd0, a_btn}, 8'd0);
    chk("rst_old", {7'd0, a_old}, 8'd0);
    chk("rst_led", {7'd0, a_led}, 8'd0);
    chk("rst_trig", {7'd0, a_trig}, 8'd0);
    chk("rst_cnt", a_cnt, 8'd0);

    // 2: clean press at edge 10, table-driven (edge c = c-th edge after reset)
    for (int c = 1; c <= 22; c++) begin
      btn = vec[c].btn;
      tick();
      chk($sformatf("vec%0d_btn", c), {7'd0, a_btn}, {7'd0, vec[c].e_btn});
      chk($sformatf("vec%0d_old", c), {7'd0, a_old}, {7'd0, vec[c].e_old});
      chk($sformatf("vec%0d_led", c), {7'd0, a_led}, {7'd0, vec[c].e_led});
      chk($sformatf("vec%0d_trig", c), {7'd0, a_trig}, {7'd0, vec[c].e_trig});
      chk($sformatf("vec%0d_cnt", c), a_cnt, vec[c].e_cnt);
    end
    hold_btn(1'b1, 30);

    // 3: bounce, o_btn rises on the 6th edge after the final fall
    ntrig_a = 0;
    hold_btn(1'b0, 3);
    hold_btn(1'b1, 1);
    btn = 1'b0;
    for (int i = 1; i <= 7; i++) begin
      tick();
      chk($sformatf("bounce_btn_e%0d", i - 1), {7'd0, a_btn}, {7'd0, (i == 7)});
    end
    repeat (4) tick();
    chk("bounce_led", {7'd0, a_led}, 8'd0);
    chk("bounce_cnt", a_cnt, 8'd2);
    chk("bounce_trigs", ntrig_a[7:0], 8'd1);
    hold_btn(1'b1, 30);

    // 4: hold-off; strobes 14 apart, then a third 34 after the second
    ntrig_a = 0;
    ntrig_b = 0;
    press_release();
    press_release();
    hold_btn(1'b1, 20);
    press_release();
    hold_btn(1'b1, 10);
    chk("hold_trigs_a", ntrig_a[7:0], 8'd3);
    chk("hold_trigs_b", ntrig_b[7:0], 8'd2);
    chk("hold_cnt_b", b_cnt, 8'd5);
    chk("hold_led_b", {7'd0, b_led}, 8'd1);

    // 5: counter wrap after 256 presses
    do_reset();
    repeat (255) press_release();
    chk("wrap_cnt255", a_cnt, 8'd255);
    press_release();
    chk("wrap_cnt0", a_cnt, 8'd0);
    chk("wrap_led", {7'd0, a_led}, 8'd0);

    // 6: reset while WAIT_P holds cnt=3 restarts the full latency
    hold_btn(1'b1, 10);
    hold_btn(1'b0, 5);
    chk("mid_pre_btn", {7'd0, a_btn}, 8'd0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int i = 1; i <= 7; i++) begin
      tick();
      chk($sformatf("mid_btn_e%0d", i - 1), {7'd0, a_btn}, {7'd0, (i == 7)});
    end
    hold_btn(1'b1, 10);

    // random bursts against the reference model
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 99) == 0) begin
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
      end
      hold_btn(1'($urandom_range(0, 1)), $urandom_range(1, 8));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
